instruction_loader: RTL

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/mips_pkg.sv | 21 ++
 rtl/byte_packer.sv | 36 +++
 rtl/instruction_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, word geometry
// and the word-index to byte-address mapping.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECEIVE = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } load_state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_CNT_W = $clog2(WORD_BYTES);

    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] index);
        return base + index * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte packer: keeps the first three bytes of a word and presents
// the full word combinationally while the fourth byte is on the bus.
module byte_packer
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clear,
    input  logic                  i_shift,
    input  logic [7:0]            i_byte,
    output logic [BYTE_CNT_W-1:0] o_count,
    output logic [31:0]           o_word
);

    localparam int SW = (WORD_BYTES - 1) * 8;

    logic [SW-1:0]         r_shift;
    logic [BYTE_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_shift) begin
            r_shift <= {r_shift[SW-9:0], i_byte};
            r_count <= r_count + BYTE_CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_word  = {r_shift, i_byte};

endmodule

// File: rtl/instruction_loader.sv
// Streams program bytes into 32-bit instruction words and writes each word to
// instruction memory at BASE_ADDR + 4*index; reports done/error per session.
module instruction_loader
    import mips_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [7:0]             byte_data,
    input  logic                   byte_valid,
    input  logic                   byte_last,
    output logic                   byte_ready,
    output logic                   mem_write,
    output logic [31:0]            mem_address,
    output logic [31:0]            mem_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [$clog2(DEPTH):0] word_count,
    output load_state_t            dbg_state
);

    localparam int IW = $clog2(DEPTH) + 1;

    load_state_t     r_state;
    logic [IW-1:0]   r_index;
    logic            r_last;
    logic            r_byte_ready;
    logic            r_mem_write;
    logic [31:0]     r_mem_address;
    logic [31:0]     r_mem_data;
    logic            r_busy;
    logic            r_done;
    logic            r_error;

    logic                  w_accept;
    logic [BYTE_CNT_W-1:0] w_count;
    logic [31:0]           w_word;

    // Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
    assign w_accept = byte_valid & r_byte_ready;

    byte_packer u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (start),
        .i_shift (w_accept),
        .i_byte  (byte_data),
        .o_count (w_count),
        .o_word  (w_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_last        <= 1'b0;
            r_byte_ready  <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= BASE_ADDR;
            r_mem_data    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else if (start) begin
            // Restart from any state; overrides a same-cycle byte or write.
            r_state       <= ST_RECEIVE;
            r_index       <= '0;
            r_last        <= 1'b0;
            r_byte_ready  <= 1'b1;
            r_mem_write   <= 1'b0;
            r_mem_address <= BASE_ADDR;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            case (r_state)
                ST_RECEIVE: begin
                    if (w_accept) begin
                        if (r_index == IW'(DEPTH)) begin
                            r_state      <= ST_ERROR;
                            r_byte_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_error      <= 1'b1;
                        end else if (w_count == BYTE_CNT_W'(WORD_BYTES - 1)) begin
                            r_state       <= ST_WRITE;
                            r_byte_ready  <= 1'b0;
                            r_mem_write   <= 1'b1;
                            r_mem_data    <= w_word;
                            r_mem_address <= word_addr(BASE_ADDR, 32'(r_index));
                            r_last        <= byte_last;
                        end else if (byte_last) begin
                            r_state      <= ST_ERROR;
                            r_byte_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_error      <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_mem_write <= 1'b0;
                    r_index     <= r_index + IW'(1);
                    if (r_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= ST_RECEIVE;
                        r_byte_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_ready  = r_byte_ready;
    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_data    = r_mem_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign word_count  = r_index;
    assign dbg_state   = r_state;

endmodule
